// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_W  = 32;
  localparam int unsigned OPCODE_W = 7;
  localparam logic [FETCH_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_W-1:0] instr;
    logic [FETCH_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [FETCH_W-1:0] word_align(input logic [FETCH_W-1:0] a);
    return a & ~FETCH_W'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush has priority over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           data_i,
  input  logic                   pop_i,
  output fetch_entry_t           data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop_i & (cnt_q != '0);
    do_push = push_i & ((cnt_q != (AW+1)'(DEPTH)) | do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited icache requests, instruction buffer, redirect drain.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                icache_req,
  output logic [XLEN-1:0]     icache_addr,
  input  logic                icache_ready,
  input  logic                icache_rvalid,
  input  logic [XLEN-1:0]     icache_rdata,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                id_ready,
  output logic                id_valid,
  output logic [XLEN-1:0]     id_instr,
  output logic [OPCODE_W-1:0] id_op,
  output logic [XLEN-1:0]     id_pc,
  output logic [XLEN-1:0]     id_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_dropped
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, target;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d, in_flight, fifo_count;
  logic [CW:0]     used_slots;
  logic            credit_ok, accept, push, pop, fifo_empty, discard;
  fetch_entry_t    push_entry, head;

  always_comb begin
    target     = word_align(redirect_pc);
    used_slots = {1'b0, out_q} + {1'b0, fifo_count};
    credit_ok  = used_slots < (CW+1)'(FIFO_DEPTH);
    in_flight  = out_q - CW'(icache_rvalid);
    accept     = icache_req & icache_ready;
    push       = icache_rvalid & (state_q == FETCH) & ~redirect_valid;
    pop        = id_valid & id_ready & ~redirect_valid;
    discard    = icache_rvalid & ((state_q == DRAIN) | redirect_valid);
    push_entry = '{instr: icache_rdata, pc: resp_pc_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Responses still in flight at a redirect must be swallowed before fetching resumes.
  always_comb begin
    state_d = state_q;
    if (redirect_valid)
      state_d = (in_flight == '0) ? FETCH : DRAIN;
    else if (state_q == DRAIN && icache_rvalid && drop_q == CW'(1))
      state_d = FETCH;
  end

  always_comb begin
    icache_req  = ~rst & (state_q == FETCH) & ~redirect_valid & credit_ok;
    icache_addr = pc_q;
  end

  // resp_pc_q is the PC of the next response that will be kept; every
  // pre-redirect response is discarded, so it restarts at the redirect target.
  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    drop_d    = drop_q;
    out_d     = out_q + CW'(accept) - CW'(icache_rvalid);
    if (redirect_valid) begin
      pc_d      = target;
      resp_pc_d = target;
      drop_d    = in_flight;
    end else begin
      if (accept) pc_d = pc_q + XLEN'(4);
      if (push)   resp_pc_d = resp_pc_q + XLEN'(4);
      if (state_q == DRAIN && icache_rvalid) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_comb begin
    id_valid    = ~fifo_empty;
    id_instr    = id_valid ? head.instr : NOP_INSTR;
    id_op       = id_instr[OPCODE_W-1:0];
    id_pc       = id_valid ? head.pc : '0;
    id_pc_plus4 = id_valid ? head.pc + XLEN'(4) : '0;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_dropped_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_q + 32'(pop);
      perf_dropped_q <= perf_dropped_q + 32'(discard)
                        + (redirect_valid ? 32'(fifo_count) : 32'd0);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: icache model, expected request/instruction queues, monitor.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready = 1'b0;
  logic        icache_rvalid = 1'b0;
  logic [31:0] icache_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [6:0]  id_op;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned acc_cnt = 0;
  logic        resp_hold = 1'b0;

  logic [31:0] exp_req_q[$];
  exp_t        exp_id_q[$];
  pend_t       pend_q[$];

  fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_req     (icache_req),
    .icache_addr    (icache_addr),
    .icache_ready   (icache_ready),
    .icache_rvalid  (icache_rvalid),
    .icache_rdata   (icache_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_op          (id_op),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[24:0] ^ 25'h1ABCDE, a[8:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    exp_req_q.push_back(pc);
    exp_id_q.push_back(e);
  endtask

  // Keep icache_ready high until exactly n more requests are accepted.
  task automatic issue(input int unsigned n);
    int unsigned tgt = acc_cnt + n;
    int unsigned g = 0;
    icache_ready = 1'b1;
    while (acc_cnt < tgt && g < 100) begin
      @(negedge clk);
      g++;
    end
    icache_ready = 1'b0;
    chk("issue_timeout", {31'b0, g < 100}, 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int unsigned g = 0;
    while ((exp_id_q.size() != 0 || exp_req_q.size() != 0 || pend_q.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk(name, {31'b0, g < 100}, 32'd1);
  endtask

  // Instruction cache model: in-order responses, lat cycles after accept.
  always @(negedge clk) begin
    #1;
    cyc++;
    icache_rvalid = 1'b0;
    icache_rdata  = '0;
    if (rst) begin
      pend_q.delete();
    end else if (!resp_hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      icache_rvalid = 1'b1;
      icache_rdata  = instr_of(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
  end

  // Monitor: checks every accepted request and every instruction consumed by decode.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (icache_req && icache_ready) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected actual=%h expected=none", icache_addr);
        end else begin
          chk("icache_addr", icache_addr, exp_req_q.pop_front());
        end
        pend_q.push_back('{addr: icache_addr, due: cyc + lat});
        acc_cnt++;
      end
      if (id_valid && id_ready && !redirect_valid) begin
        if (exp_id_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL id_unexpected actual_pc=%h expected=none", id_pc);
        end else begin
          exp_t e;
          e = exp_id_q.pop_front();
          chk("id_instr", id_instr, e.instr);
          chk("id_pc", id_pc, e.pc);
          chk("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
          chk("id_op", {25'b0, id_op}, {25'b0, e.instr[6:0]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #3;
    chk("rst_req", {31'b0, icache_req}, 32'd0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'h0000_0013);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_pc4", id_pc_plus4, 32'd0);

    // Straight-line fetch from RESET_PC.
    @(negedge clk);
    rst = 1'b0;
    id_ready = 1'b1;
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    expect_fetch(32'h8);
    issue(3);
    wait_drain("drain_seq");

    // Request held while icache not ready.
    repeat (3) begin
      @(negedge clk);
      #3;
      chk("hold_req", {31'b0, icache_req}, 32'd1);
      chk("hold_addr", icache_addr, 32'hC);
    end
    @(negedge clk);
    expect_fetch(32'hC);
    expect_fetch(32'h10);
    issue(2);
    wait_drain("drain_hold");

    // Decode stalled: buffer fills, credit stops further requests.
    lat = 2;
    id_ready = 1'b0;
    expect_fetch(32'h14);
    expect_fetch(32'h18);
    icache_ready = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    chk("full_req", {31'b0, icache_req}, 32'd0);
    chk("full_valid", {31'b0, id_valid}, 32'd1);
    chk("full_head", id_pc, 32'h14);
    @(negedge clk);
    icache_ready = 1'b0;
    id_ready = 1'b1;
    wait_drain("drain_stall");
    lat = 1;

    // Redirect with two requests in flight: both responses discarded.
    resp_hold = 1'b1;
    exp_req_q.push_back(32'h1C);
    exp_req_q.push_back(32'h20);
    issue(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    redirect_valid = 1'b0;
    resp_hold = 1'b0;
    #3;
    chk("drain_noreq", {31'b0, icache_req}, 32'd0);
    @(negedge clk);
    expect_fetch(32'h100);
    issue(1);
    wait_drain("drain_redir");
`ifdef FETCH_PERF_EN
    chk("perf_dropped_a", perf_dropped, 32'd2);
`endif

    // Redirect coinciding with rvalid and a decode pop.
    id_ready = 1'b0;
    resp_hold = 1'b1;
    exp_req_q.push_back(32'h104);
    exp_req_q.push_back(32'h108);
    issue(2);
    resp_hold = 1'b0;
    @(negedge clk);
    resp_hold = 1'b1;
    @(negedge clk);
    resp_hold = 1'b0;
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #3;
    chk("same_empty", {31'b0, id_valid}, 32'd0);
    chk("same_req", {31'b0, icache_req}, 32'd1);
    chk("same_addr", icache_addr, 32'h200);
    @(negedge clk);
    expect_fetch(32'h200);
    issue(1);
    wait_drain("drain_same");
`ifdef FETCH_PERF_EN
    chk("perf_fetched_b", perf_fetched, 32'd9);
    chk("perf_dropped_b", perf_dropped, 32'd4);
`endif

    // Reset asserted while draining.
    resp_hold = 1'b1;
    exp_req_q.push_back(32'h204);
    exp_req_q.push_back(32'h208);
    issue(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    rst = 1'b1;
    #3;
    chk("mid_rst_req", {31'b0, icache_req}, 32'd0);
    chk("mid_rst_valid", {31'b0, id_valid}, 32'd0);
    chk("mid_rst_instr", id_instr, 32'h0000_0013);
    chk("mid_rst_pc", id_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    resp_hold = 1'b0;
    expect_fetch(32'h0);
    issue(1);
    wait_drain("drain_rst");
`ifdef FETCH_PERF_EN
    chk("perf_fetched_c", perf_fetched, 32'd1);
    chk("perf_dropped_c", perf_dropped, 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
